// File: rtl/audio_serial_rx.sv
// audio_serial_rx: oversampling receiver for the three-wire serial audio link
// (bck / ws / sdata). Deserialises MSB-first channel words into parallel
// samples with a one-cycle valid strobe, and tracks frame lock with a
// bit-clock watchdog.
// Optional build macro AUDIO_RX_LJ_EN selects left-justified framing;
// without it the receiver uses standard I2S one-bit-delayed framing.
module audio_serial_rx #(
  parameter int SAMPLE_W    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                bck_i,
  input  logic                ws_i,
  input  logic                sdata_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                right_o,
  output logic                valid_o,
  output logic                short_o,
  output logic                locked_o
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [SAMPLE_W-1:0] MSB_ONE  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] WD_TERM = '1;

  typedef enum logic {HUNT, RUN} state_t;

  // Synchroniser chains, bck history flop and the two-stage event pipe
  logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q,  ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q,  sd_sync_d;
  logic                   bck_hist_q, bck_hist_d;
  logic [1:0]             ev_pipe_q,  ev_pipe_d;
  logic [1:0]             ev_ws_q,    ev_ws_d;
  logic [1:0]             ev_sd_q,    ev_sd_d;

  // Framing / capture state
  state_t                 state_q,    state_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic [SAMPLE_W-1:0]    sr_q,       sr_d;
  logic                   chan_q,     chan_d;
  logic                   ws_prev_q,  ws_prev_d;
  logic                   prev_vld_q, prev_vld_d;
  logic [TIMEOUT_W-1:0]   wd_q,       wd_d;

  // Registered outputs
  logic [SAMPLE_W-1:0]    sample_q,   sample_d;
  logic                   right_q,    right_d;
  logic                   valid_q,    valid_d;
  logic                   short_q,    short_d;
  logic                   locked_q,   locked_d;

  // Input path: shift the pins through the synchronisers and detect bck rise.
  // ws/sdata are taken from the last sync stage, aligned with the bck rise,
  // then carried down a two-deep pipe so the rise lands SYNC_STAGES+2 later.
  logic rise;
  always_comb begin
    bck_sync_d = {bck_sync_q[SYNC_STAGES-2:0], bck_i};
    ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0],  ws_i};
    sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0],  sdata_i};
    bck_hist_d = bck_sync_q[SYNC_STAGES-1];
    rise       = bck_sync_q[SYNC_STAGES-1] & ~bck_hist_q;
    ev_pipe_d  = {ev_pipe_q[0], rise};
    ev_ws_d    = {ev_ws_q[0], ws_sync_q[SYNC_STAGES-1]};
    ev_sd_d    = {ev_sd_q[0], sd_sync_q[SYNC_STAGES-1]};
  end

  // Framing FSM, bit capture, word completion and watchdog
  logic                ev, ws_e, sd_e, boundary;
  logic [SAMPLE_W-1:0] sr_cap, sr_first;
  logic [CNT_W-1:0]    cnt_cap;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    chan_d     = chan_q;
    ws_prev_d  = ws_prev_q;
    prev_vld_d = prev_vld_q;
    wd_d       = wd_q;
    sample_d   = sample_q;
    right_d    = right_q;
    valid_d    = 1'b0;
    short_d    = 1'b0;
    locked_d   = locked_q;

    ev       = ev_pipe_q[1];
    ws_e     = ev_ws_q[1];
    sd_e     = ev_sd_q[1];
    boundary = ev & prev_vld_q & (ws_e != ws_prev_q);

    // sr is kept left-aligned: bit n of the slot lands at SAMPLE_W-1-n,
    // so unfilled LSBs are already zero at completion.
    if (cnt_q < CNT_FULL) begin
      sr_cap  = sd_e ? (sr_q | (MSB_ONE >> cnt_q)) : sr_q;
      cnt_cap = cnt_q + CNT_ONE;
    end else begin
      sr_cap  = sr_q;
      cnt_cap = cnt_q;
    end
    sr_first = sd_e ? MSB_ONE : '0;

    // Watchdog reloads on every rise and saturates at terminal count
    if (ev) begin
      ws_prev_d  = ws_e;
      prev_vld_d = 1'b1;
      wd_d       = WD_ONE;
    end else if (wd_q != WD_TERM) begin
      wd_d = wd_q + WD_ONE;
    end

    case (state_q)
      HUNT: begin
        locked_d = 1'b0;
        if (boundary) begin
          state_d  = RUN;
          locked_d = 1'b1;
          chan_d   = ws_e;
`ifdef AUDIO_RX_LJ_EN
          sr_d     = sr_first;
          cnt_d    = CNT_ONE;
`else
          sr_d     = '0;
          cnt_d    = '0;
`endif
        end
      end
      RUN: begin
        if (boundary) begin
          valid_d = 1'b1;
          right_d = chan_q;
          chan_d  = ws_e;
`ifdef AUDIO_RX_LJ_EN
          // Close the word first; this edge's bit opens the next word
          sample_d = sr_q;
          short_d  = (cnt_q < CNT_FULL);
          sr_d     = sr_first;
          cnt_d    = CNT_ONE;
`else
          // The boundary bit is the LSB of the closing word
          sample_d = sr_cap;
          short_d  = (cnt_cap < CNT_FULL);
          sr_d     = '0;
          cnt_d    = '0;
`endif
        end else if (ev) begin
          sr_d  = sr_cap;
          cnt_d = cnt_cap;
        end else if (wd_q == WD_TERM) begin
          // bck stalled: drop lock and throw away the partial word
          state_d  = HUNT;
          locked_d = 1'b0;
          sr_d     = '0;
          cnt_d    = '0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State register: every flop cleared by the asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      bck_hist_q <= 1'b0;
      ev_pipe_q  <= '0;
      ev_ws_q    <= '0;
      ev_sd_q    <= '0;
      state_q    <= HUNT;
      cnt_q      <= '0;
      sr_q       <= '0;
      chan_q     <= 1'b0;
      ws_prev_q  <= 1'b0;
      prev_vld_q <= 1'b0;
      wd_q       <= '0;
      sample_q   <= '0;
      right_q    <= 1'b0;
      valid_q    <= 1'b0;
      short_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      bck_sync_q <= bck_sync_d;
      ws_sync_q  <= ws_sync_d;
      sd_sync_q  <= sd_sync_d;
      bck_hist_q <= bck_hist_d;
      ev_pipe_q  <= ev_pipe_d;
      ev_ws_q    <= ev_ws_d;
      ev_sd_q    <= ev_sd_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      chan_q     <= chan_d;
      ws_prev_q  <= ws_prev_d;
      prev_vld_q <= prev_vld_d;
      wd_q       <= wd_d;
      sample_q   <= sample_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      short_q    <= short_d;
      locked_q   <= locked_d;
    end
  end

  assign sample_o = sample_q;
  assign right_o  = right_q;
  assign valid_o  = valid_q;
  assign short_o  = short_q;
  assign locked_o = locked_q;

endmodule

// File: tb/tb_audio_serial_rx.sv
// Directed bench for audio_serial_rx: drives bck at clk/8 and checks the
// reported words, strobes, lock and watchdog behaviour. The framing used by
// the driver follows AUDIO_RX_LJ_EN so the same expectations hold in both builds.
module tb_audio_serial_rx;

`ifdef AUDIO_RX_LJ_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        bck_i = 1'b0;
  logic        ws_i = 1'b0;
  logic        sdata_i = 1'b0;
  logic [15:0] sample_o;
  logic        right_o, valid_o, short_o, locked_o;

  audio_serial_rx dut (
    .clk_i(clk_i), .rst_i(rst_i), .bck_i(bck_i), .ws_i(ws_i), .sdata_i(sdata_i),
    .sample_o(sample_o), .right_o(right_o), .valid_o(valid_o),
    .short_o(short_o), .locked_o(locked_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] s;
    logic        r;
    logic        sh;
    int          lat;
  } ev_t;

  ev_t  evq[$];
  int   cyc = 0;
  int   last_rise = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic carry = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every valid strobe with its latency from the driving bck rise
  always @(negedge clk_i) begin
    if (valid_o) evq.push_back('{s: sample_o, r: right_o, sh: short_o, lat: cyc - last_rise - 1});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_ev(input string tag, input int idx, input logic r, input logic [15:0] s,
                        input logic sh);
    if (idx >= evq.size()) begin
      n_total++;
      $error("FAIL %s: observed no event #%0d expected right=%0b sample=%0h", tag, idx, r, s);
    end else begin
      chk({tag, "_right"}, 32'(evq[idx].r), 32'(r));
      chk({tag, "_sample"}, 32'(evq[idx].s), 32'(s));
      chk({tag, "_short"}, 32'(evq[idx].sh), 32'(sh));
    end
  endtask

  // One bck period: low half with ws/sdata set up, then the rise
  task automatic bck_bit(input logic ws, input logic sd);
    ws_i = ws; sdata_i = sd; bck_i = 1'b0;
    repeat (4) @(negedge clk_i);
    bck_i = 1'b1;
    last_rise = cyc;
    repeat (4) @(negedge clk_i);
  endtask

  // data holds the slot bits MSB first from bit 31
  task automatic send_slot(input logic c, input logic [31:0] data, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      if (LJ) bck_bit(c, data[31-k]);
      else    bck_bit(c, (k == 0) ? carry : data[32-k]);
    end
    if (!LJ) carry = data[32-nbits];
  endtask

  // Single rise on the opposite channel to close the last word
  task automatic tail(input logic c);
    bck_bit(c, LJ ? 1'b0 : carry);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; bck_i = 1'b0; ws_i = 1'b0; sdata_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    carry = 1'b0;
    repeat (2) @(negedge clk_i);
    evq.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_sample", 32'(sample_o), 32'h0);
    chk("rst_right", 32'(right_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_short", 32'(short_o), 32'h0);
    chk("rst_locked", 32'(locked_o), 32'h0);

    // 16-bit slots, three frames of L=A55A / R=1234
    do_reset();
    send_slot(1'b1, 32'h0, 16);
    for (int f = 0; f < 3; f++) begin
      send_slot(1'b0, {16'hA55A, 16'h0}, 16);
      send_slot(1'b1, {16'h1234, 16'h0}, 16);
    end
    tail(1'b0);
    repeat (8) @(negedge clk_i);
    chk("t1_nev", 32'(evq.size()), 32'd6);
    for (int i = 0; i < 6; i += 2) begin
      chk_ev("t1_L", i, 1'b0, 16'hA55A, 1'b0);
      chk_ev("t1_R", i + 1, 1'b1, 16'h1234, 1'b0);
    end
    if (evq.size() > 0) chk("t1_latency", 32'(evq[0].lat), 32'd4);
    chk("t1_locked", 32'(locked_o), 32'h1);

    // 32-bit slots with trailing ones
    do_reset();
    send_slot(1'b1, 32'h0, 32);
    send_slot(1'b0, {16'h8001, 16'hFFFF}, 32);
    send_slot(1'b1, {16'h7FFE, 16'hFFFF}, 32);
    tail(1'b0);
    repeat (8) @(negedge clk_i);
    chk("t2_nev", 32'(evq.size()), 32'd2);
    chk_ev("t2_L", 0, 1'b0, 16'h8001, 1'b0);
    chk_ev("t2_R", 1, 1'b1, 16'h7FFE, 1'b0);

    // 12-bit slots: short words, left-aligned
    do_reset();
    send_slot(1'b1, 32'h0, 12);
    send_slot(1'b0, {12'hABC, 20'h0}, 12);
    send_slot(1'b1, {12'hABC, 20'h0}, 12);
    tail(1'b0);
    repeat (8) @(negedge clk_i);
    chk("t3_nev", 32'(evq.size()), 32'd2);
    chk_ev("t3_L", 0, 1'b0, 16'hABC0, 1'b1);
    chk_ev("t3_R", 1, 1'b1, 16'hABC0, 1'b1);

    // bck stalls mid right word: watchdog drops lock, then relock
    do_reset();
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, {16'hA55A, 16'h0}, 16);
    send_slot(1'b1, {16'h1234, 16'h0}, 8);
    begin
      int t0;
      int fall;
      t0 = last_rise;
      fall = -1;
      for (int i = 0; i < 400 && fall < 0; i++) begin
        @(negedge clk_i);
        if (!locked_o) fall = cyc - t0 - 1;
      end
      chk("t4_wd_fall", 32'(fall), 32'd259);
    end
    repeat (40) @(negedge clk_i);
    chk("t4_nev_stall", 32'(evq.size()), 32'd1);
    chk("t4_hold_sample", 32'(sample_o), 32'hA55A);
    chk("t4_hold_right", 32'(right_o), 32'h0);
    chk("t4_unlocked", 32'(locked_o), 32'h0);
    evq.delete();
    send_slot(1'b0, {16'h5A5A, 16'h0}, 16);
    send_slot(1'b1, {16'h1234, 16'h0}, 16);
    tail(1'b0);
    repeat (8) @(negedge clk_i);
    chk("t4_nev_relock", 32'(evq.size()), 32'd2);
    chk_ev("t4_L", 0, 1'b0, 16'h5A5A, 1'b0);
    chk_ev("t4_R", 1, 1'b1, 16'h1234, 1'b0);

    // Reset for one cycle in the middle of a right word
    do_reset();
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, {16'hA55A, 16'h0}, 16);
    send_slot(1'b1, {16'h1234, 16'h0}, 8);
    chk("t5_nev_pre", 32'(evq.size()), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("t5_rst_sample", 32'(sample_o), 32'h0);
    chk("t5_rst_locked", 32'(locked_o), 32'h0);
    chk("t5_rst_right", 32'(right_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    evq.delete();
    carry = 1'b0;
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, {16'h1111, 16'h0}, 16);
    send_slot(1'b1, {16'h2222, 16'h0}, 16);
    tail(1'b0);
    repeat (8) @(negedge clk_i);
    chk("t5_nev_post", 32'(evq.size()), 32'd2);
    chk_ev("t5_L", 0, 1'b0, 16'h1111, 1'b0);
    chk_ev("t5_R", 1, 1'b1, 16'h2222, 1'b0);

    // F00F / 0FF0 words
    do_reset();
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, {16'hF00F, 16'h0}, 16);
    send_slot(1'b1, {16'h0FF0, 16'h0}, 16);
    tail(1'b0);
    repeat (8) @(negedge clk_i);
    chk("t6_nev", 32'(evq.size()), 32'd2);
    chk_ev("t6_L", 0, 1'b0, 16'hF00F, 1'b0);
    chk_ev("t6_R", 1, 1'b1, 16'h0FF0, 1'b0);
    if (evq.size() > 1) chk("t6_latency", 32'(evq[1].lat), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_serial_rx.md
Name: audio_serial_rx

Overview:
- Receiver end of the board's three-wire serial audio DAC link (data, word-select, bit-clock), clocked by the system clock.
- Deserialises the I2S stream into parallel per-channel samples with a valid strobe.
- Used for on-board loopback/self-test of the DAC serialiser and as the audio-input path from an external serial source.
- Oversamples the link pins: bck must run at most clk_i/4.

Parameters:
- SAMPLE_W, 16: bits kept per channel word, MSB first.
- SYNC_STAGES, 2: synchroniser flops on each link input (min 2).
- TIMEOUT_W, 8: width of the bit-clock watchdog; lock drops after 2^TIMEOUT_W-1 clk_i cycles without a bck rising edge.

Ports:
- clk_i  in  1  system clock (tg42 domain)
- rst_i  in  1  asynchronous, active-high reset
- bck_i  in  1  serial bit clock, asynchronous to clk_i
- ws_i  in  1  word select; 0 = left, 1 = right
- sdata_i  in  1  serial data
- sample_o  out  SAMPLE_W  last completed word
- right_o  out  1  channel of sample_o (1 = right)
- valid_o  out  1  one-cycle strobe: sample_o/right_o updated
- short_o  out  1  one-cycle strobe with valid_o: slot had fewer than SAMPLE_W bits
- locked_o  out  1  receiver framed to ws

Behaviour:
- Reset (async, active-high): all flops cleared. sample_o=0, right_o=0, valid_o=0, short_o=0, locked_o=0; FSM in HUNT.
- Input path:
  - bck_i, ws_i and sdata_i each pass SYNC_STAGES flops, then one history flop.
  - Rise event = synced bck 0->1.
  - ws and sdata are taken from the same synchronised stage as bck at the rise event.
- Boundary event: rise event where the sampled ws differs from the ws sampled at the previous rise event.
- I2S framing (default):
  - A channel word is the bits at rise events from (boundary+1) up to and including the next boundary.
  - The word's channel is the ws value sampled at the opening boundary.
- Bit capture:
  - Counter cnt counts captured bits in the current slot and saturates at SAMPLE_W.
  - Bits are shifted into shift register sr while cnt<SAMPLE_W.
  - Bits beyond SAMPLE_W are ignored with no error.
- Word completion, at the closing boundary:
  - sample_o = sr left-aligned; missing LSBs are 0.
  - right_o = slot channel.
  - valid_o=1 for exactly one clk_i.
  - short_o=1 in the same cycle if cnt<SAMPLE_W.
  - Then cnt=0 and sr=0.
- Latency: valid_o asserts SYNC_STAGES+2 clk_i cycles after the first clk_i edge that samples bck_i high at the closing boundary.
- FSM:
  - HUNT: locked_o=0, no valid_o. The first boundary event moves to RUN, sets locked_o=1 and clears cnt/sr. The partial word is discarded, with no valid_o.
  - RUN: normal capture/completion.
  - Watchdog: counter reloads on every rise event. On terminal count go to HUNT, locked_o=0, discard the partial word; sample_o and right_o hold their last values.
- Boundary conditions:
  - Back-to-back boundaries (1-bit slots) each complete a word, short_o=1.
  - Boundary and watchdog expiry in the same cycle: the boundary wins (rise event reloads the watchdog).
  - Reset mid-word: word lost; after release, HUNT is re-entered.
  - sample_o, right_o and locked_o are registered outputs with no combinational path from the inputs.

Optional Feature:
- Macro AUDIO_RX_LJ_EN.
- Defined: left-justified framing. A word is the bits at rise events from the boundary itself through the rise event before the next boundary. The MSB is taken at the boundary. At the closing boundary the word completes before that edge's bit is captured; that bit becomes the MSB of the next word. Latency and strobes are unchanged.
- Undefined: standard I2S one-bit-delayed framing as above.

Test Plan:
- I2S, 16 bck per slot, bck=clk/8; send L=0xA55A, R=0x1234 for 3 frames -> after the first lock boundary: valid_o pulses with (right_o=0, 0xA55A) and (right_o=1, 0x1234) alternately, short_o=0, locked_o=1.
- 32 bck per slot, MSB-first words L=0x8001, R=0x7FFE padded with trailing ones -> sample_o=0x8001 / 0x7FFE, short_o=0.
- 12-bit slots carrying 0xABC -> sample_o=0xABC0 with short_o=1 on each valid_o.
- Stop bck mid-word for 300 clk_i (TIMEOUT_W=8) -> locked_o falls after 255 cycles, no valid_o; on restart the first boundary relocks with no valid_o, and the next word is correct.
- Assert rst_i for 1 cycle mid right-slot -> all outputs 0 immediately; the partial word is never reported.
- With AUDIO_RX_LJ_EN, left-justified L=0xF00F, R=0x0FF0 at 16 bck/slot -> same values reported, valid_o at the closing boundary.
